// File: rtl/imem_refill_arbiter.sv
// imem_refill_arbiter: lets the I-cache refill port (I) and the core data
// port (D) share one single-word memory port. Only one side owns the port at a
// time. The owner's request is forwarded to memory, and the ready pulse and
// read data are routed back to that owner. After each completed I word, the
// port is held for I for a short window, so that a line refill is not
// interleaved with data traffic. The hold is bounded by BURST_LEN words.
module imem_refill_arbiter #(
  parameter int DATA_W        = 32,
  parameter int BURST_LEN     = 4,
  parameter int HOLD_WINDOW   = 2,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [31:0]           i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [31:0]           d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [31:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  grant_i,
  output logic                  grant_d
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int HW = $clog2(HOLD_WINDOW + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GNT_I,
    ST_GNT_D,
    ST_GAP,
    ST_HOLD_I
  } state_e;

  state_e        state_q, state_d;
  logic          last_is_d_q, last_is_d_d;   // 1 when D completed most recently
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] burst_inc;
  logic [HW-1:0] hold_inc;

  // State register. Reset makes last owner D, so that I wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_is_d_q <= 1'b1;
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_is_d_q <= last_is_d_d;
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state logic: arbitration, completion/abort handling, hold window.
  always_comb begin
    state_d     = state_q;
    last_is_d_d = last_is_d_q;
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    burst_inc   = burst_cnt_q + BW'(1);
    hold_inc    = hold_cnt_q + HW'(1);
    case (state_q)
      ST_IDLE: begin
        if (i_valid && d_valid) begin
          if (PRIORITY_MODE == 1)  state_d = ST_GNT_D;
          else if (last_is_d_q)    state_d = ST_GNT_I;
          else                     state_d = ST_GNT_D;
        end else if (i_valid) begin
          state_d = ST_GNT_I;
        end else if (d_valid) begin
          state_d = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        // A dropped valid wins over a coincident mem_ready: the request is gone.
        if (!i_valid) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
        end else if (mem_ready) begin
          last_is_d_d = 1'b0;
          if (burst_inc < BW'(BURST_LEN)) begin
            burst_cnt_d = burst_inc;
            hold_cnt_d  = '0;
            state_d     = ST_HOLD_I;
          end else begin
            burst_cnt_d = '0;
            state_d     = ST_GAP;
          end
        end
      end
      ST_GNT_D: begin
        if (!d_valid) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
        end else if (mem_ready) begin
          last_is_d_d = 1'b1;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        // One dead cycle hides the requester's stale valid after its ready.
        state_d = ST_IDLE;
      end
      ST_HOLD_I: begin
        if (i_valid) begin
          state_d = ST_GNT_I;
        end else begin
          hold_cnt_d = hold_inc;
          if (hold_inc == HW'(HOLD_WINDOW)) begin
            burst_cnt_d = '0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: forward the owner's request and route ready back to it.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        mem_valid = i_valid;
        mem_addr  = i_addr;
        i_ready   = i_valid & mem_ready;
        grant_i   = 1'b1;
      end
      ST_GNT_D: begin
        mem_valid = d_valid;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
        d_ready   = d_valid & mem_ready;
        grant_d   = 1'b1;
      end
      ST_HOLD_I: grant_i = 1'b1;
      default: ;
    endcase
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Bench for imem_refill_arbiter: directed scenarios followed by a long
// randomized run. The run is checked against a transaction-level model of who
// owns the port.
module tb_imem_refill_arbiter;

  localparam int DATA_W        = 32;
  localparam int BURST_LEN     = 4;
  localparam int HOLD_WINDOW   = 2;
  localparam int PRIORITY_MODE = 0;
  localparam int SW            = DATA_W / 8;
  localparam int VW            = 5 + 32 + DATA_W + SW + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_valid = 1'b0, d_valid = 1'b0, mem_ready = 1'b0;
  logic              i_ready, d_ready, mem_valid, grant_i, grant_d;
  logic [31:0]       i_addr = '0, d_addr = '0, mem_addr;
  logic [DATA_W-1:0] d_wdata = '0, mem_rdata = '0, i_rdata, d_rdata, mem_wdata;
  logic [SW-1:0]     d_wstrb = '0, mem_wstrb;
  logic [VW-1:0]     dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  imem_refill_arbiter #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .HOLD_WINDOW(HOLD_WINDOW), .PRIORITY_MODE(PRIORITY_MODE)
  ) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  assign dut_vec = {mem_valid, i_ready, d_ready, grant_i, grant_d,
                    mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata};

  // Reference model: who is being served, whether the port sits in its
  // post-ready dead cycle, how much of an I hold window is left, and how many
  // words the current I burst has completed.
  bit m_busy_i = 0, m_busy_d = 0, m_gap = 0, m_last_i = 0;
  int m_hold_left = 0, m_words = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy_i <= 0; m_busy_d <= 0; m_gap <= 0; m_last_i <= 0;
      m_hold_left <= 0; m_words <= 0;
    end else if (m_busy_i) begin
      if (!i_valid) begin
        m_busy_i <= 0; m_words <= 0;
      end else if (mem_ready) begin
        m_busy_i <= 0; m_last_i <= 1;
        if (m_words + 1 < BURST_LEN) begin
          m_words <= m_words + 1; m_hold_left <= HOLD_WINDOW;
        end else begin
          m_words <= 0; m_gap <= 1;
        end
      end
    end else if (m_busy_d) begin
      if (!d_valid) begin
        m_busy_d <= 0; m_words <= 0;
      end else if (mem_ready) begin
        m_busy_d <= 0; m_last_i <= 0; m_gap <= 1;
      end
    end else if (m_gap) begin
      m_gap <= 0;
    end else if (m_hold_left > 0) begin
      if (i_valid) begin
        m_hold_left <= 0; m_busy_i <= 1;
      end else begin
        m_hold_left <= m_hold_left - 1;
        if (m_hold_left == 1) m_words <= 0;
      end
    end else if (i_valid && (!d_valid || (PRIORITY_MODE == 0 && !m_last_i))) begin
      m_busy_i <= 1;
    end else if (d_valid) begin
      m_busy_d <= 1;
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic mv, ir, dr, gi, gd;
    logic [31:0] a;
    logic [DATA_W-1:0] wd;
    logic [SW-1:0] ws;
    mv = (m_busy_i & i_valid) | (m_busy_d & d_valid);
    ir = m_busy_i & i_valid & mem_ready;
    dr = m_busy_d & d_valid & mem_ready;
    gi = m_busy_i | (m_hold_left > 0);
    gd = m_busy_d;
    a  = m_busy_i ? i_addr : (m_busy_d ? d_addr : 32'h0);
    wd = m_busy_d ? d_wdata : '0;
    ws = m_busy_d ? d_wstrb : '0;
    return {mv, ir, dr, gi, gd, a, wd, ws, mem_rdata, mem_rdata};
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; i_valid = 1; i_addr = 32'h55; mem_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_valid, i_ready, d_ready, grant_i, grant_d} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {mem_valid, i_ready, d_ready, grant_i, grant_d});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_bad++;
      $display("FAIL reset_forwarding: got %h/%h/%h want zeros", mem_addr, mem_wdata, mem_wstrb);
    end
    i_valid = 0; mem_ready = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_first_grant();
    logic [DATA_W-1:0] rd;
    i_valid = 1; i_addr = 32'h100;
    #1;
    n_cmp++;
    if (mem_valid !== 1'b0) begin
      n_bad++; $display("FAIL first_grant_latency: mem_valid got %b want 0", mem_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_valid, grant_i, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 32'h100, {SW{1'b0}}}) begin
      n_bad++;
      $display("FAIL first_grant_fwd: got v=%b g=%b a=%h s=%h want v=1 g=1 a=00000100 s=0",
               mem_valid, grant_i, mem_addr, mem_wstrb);
    end
    @(negedge clk);
    rd = 32'hA5A5_0100; mem_ready = 1; mem_rdata = rd;
    #1;
    n_cmp++;
    if ({i_ready, d_ready, i_rdata} !== {1'b1, 1'b0, rd}) begin
      n_bad++;
      $display("FAIL first_grant_ready: got ir=%b dr=%b rd=%h want ir=1 dr=0 rd=%h",
               i_ready, d_ready, i_rdata, rd);
    end
    @(negedge clk);
    i_valid = 0; mem_ready = 0;
    idle_cycles(4);
  endtask

  task automatic test_d_write();
    int pulses_d = 0, pulses_i = 0;
    logic [DATA_W-1:0] rd = '0;
    @(negedge clk);
    d_valid = 1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_valid, grant_d, grant_i, mem_addr, mem_wdata, mem_wstrb} !==
        {1'b1, 1'b1, 1'b0, 32'h3000, 32'hDEADBEEF, 4'hF}) begin
      n_bad++;
      $display("FAIL d_write_fwd: got v=%b gd=%b gi=%b a=%h w=%h s=%h want 1 1 0 00003000 deadbeef f",
               mem_valid, grant_d, grant_i, mem_addr, mem_wdata, mem_wstrb);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ready = (k == 2); rd = $urandom; mem_rdata = rd;
      #1;
      if (d_ready) pulses_d++;
      if (i_ready) pulses_i++;
    end
    n_cmp++;
    if (d_rdata !== rd) begin
      n_bad++; $display("FAIL d_write_rdata: got %h want %h", d_rdata, rd);
    end
    @(negedge clk);
    mem_ready = 0;
    #1;
    n_cmp++;
    if ({mem_valid, grant_d} !== 2'b00) begin
      n_bad++; $display("FAIL d_write_gap: got v=%b gd=%b want 0 0", mem_valid, grant_d);
    end
    d_valid = 0;
    n_cmp++;
    if (pulses_d != 1 || pulses_i != 0) begin
      n_bad++; $display("FAIL d_write_pulses: got d=%0d i=%0d want d=1 i=0", pulses_d, pulses_i);
    end
    idle_cycles(2);
  endtask

  task automatic test_burst_refill();
    int d_seen = 0;
    bit got;
    @(negedge clk);
    d_valid = 1; d_addr = 32'h4000; d_wdata = 32'h1234_5678; d_wstrb = '0;
    for (int w = 0; w < BURST_LEN; w++) begin
      i_valid = 1; i_addr = 32'h200 + 32'(4 * w);
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clk); #1;
        if (grant_d) d_seen++;
        if (mem_valid && grant_i) got = 1;
      end
      n_cmp++;
      if (!got || mem_addr !== i_addr) begin
        n_bad++;
        $display("FAIL burst_word%0d_grant: got granted=%0d a=%h want granted=1 a=%h",
                 w, got, mem_addr, i_addr);
      end
      @(negedge clk);
      mem_ready = 1; mem_rdata = $urandom;
      #1;
      if (grant_d) d_seen++;
      n_cmp++;
      if (i_ready !== 1'b1) begin
        n_bad++; $display("FAIL burst_word%0d_ready: got %b want 1", w, i_ready);
      end
      @(negedge clk);
      mem_ready = 0; i_valid = 0;
      #1;
      if (grant_d) d_seen++;
      if (w < BURST_LEN - 1) @(negedge clk);
    end
    n_cmp++;
    if (d_seen != 0 || {grant_i, grant_d, mem_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL burst_gap: got d_grants=%0d gi=%b gd=%b v=%b want 0 0 0 0",
               d_seen, grant_i, grant_d, mem_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (grant_d !== 1'b0) begin
      n_bad++; $display("FAIL burst_idle: grant_d got %b want 0", grant_d);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_d, mem_valid, mem_addr} !== {1'b1, 1'b1, 32'h4000}) begin
      n_bad++;
      $display("FAIL burst_d_after: got gd=%b v=%b a=%h want 1 1 00004000", grant_d, mem_valid, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    n_cmp++;
    if (d_ready !== 1'b1) begin
      n_bad++; $display("FAIL burst_d_ready: got %b want 1", d_ready);
    end
    @(negedge clk);
    mem_ready = 0; d_valid = 0;
    idle_cycles(3);
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    i_valid = 1; d_valid = 1; i_addr = 32'h600; d_addr = 32'h700; d_wstrb = '0;
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, grant_d, mem_addr} !== {1'b1, 1'b0, 32'h600}) begin
      n_bad++;
      $display("FAIL rr_first_tie: got gi=%b gd=%b a=%h want 1 0 00000600", grant_i, grant_d, mem_addr);
    end
    @(negedge clk); mem_ready = 1;
    @(negedge clk); mem_ready = 0; i_valid = 0; d_valid = 0;
    idle_cycles(4);
    i_valid = 1; d_valid = 1;
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, grant_d, mem_addr} !== {1'b0, 1'b1, 32'h700}) begin
      n_bad++;
      $display("FAIL rr_second_tie: got gi=%b gd=%b a=%h want 0 1 00000700", grant_i, grant_d, mem_addr);
    end
    @(negedge clk); mem_ready = 1;
    @(negedge clk); mem_ready = 0; i_valid = 0; d_valid = 0;
    idle_cycles(4);
  endtask

  task automatic test_hold_expiry();
    @(negedge clk);
    i_valid = 1; i_addr = 32'h800;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1;
    #1;
    n_cmp++;
    if (i_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_word1_ready: got %b want 1", i_ready);
    end
    for (int h = 0; h < HOLD_WINDOW; h++) begin
      @(negedge clk);
      mem_ready = 0; i_valid = 0; d_valid = 1; d_addr = 32'h900;
      #1;
      n_cmp++;
      if ({grant_i, grant_d, mem_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got gi=%b gd=%b v=%b want 1 0 0", h, grant_i, grant_d, mem_valid);
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, grant_d, mem_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL hold_expired_idle: got gi=%b gd=%b v=%b want 0 0 0", grant_i, grant_d, mem_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, grant_d, mem_valid, mem_addr} !== {3'b011, 32'h900}) begin
      n_bad++;
      $display("FAIL hold_d_granted: got gi=%b gd=%b v=%b a=%h want 0 1 1 00000900",
               grant_i, grant_d, mem_valid, mem_addr);
    end
    @(negedge clk); mem_ready = 1;
    @(negedge clk); mem_ready = 0; d_valid = 0;
    idle_cycles(3);
  endtask

  task automatic test_abort_stray();
    @(negedge clk);
    mem_ready = 1;
    #1;
    n_cmp++;
    if ({i_ready, d_ready, mem_valid} !== 3'b000) begin
      n_bad++; $display("FAIL stray_ready_idle: got %b want 000", {i_ready, d_ready, mem_valid});
    end
    @(negedge clk);
    mem_ready = 0; i_valid = 1; i_addr = 32'hA00;
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, mem_valid} !== 2'b11) begin
      n_bad++; $display("FAIL abort_pre_grant: got gi=%b v=%b want 1 1", grant_i, mem_valid);
    end
    @(negedge clk);
    i_valid = 0; mem_ready = 1;
    #1;
    n_cmp++;
    if ({i_ready, d_ready, mem_valid} !== 3'b000) begin
      n_bad++; $display("FAIL abort_no_ready: got %b want 000", {i_ready, d_ready, mem_valid});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({grant_i, grant_d, i_ready, d_ready} !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_to_idle: got %b want 0000", {grant_i, grant_d, i_ready, d_ready});
    end
    mem_ready = 0;
    idle_cycles(2);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    d_valid = 1; d_addr = 32'hB00;
    @(negedge clk); #1;
    n_cmp++;
    if (grant_d !== 1'b1) begin
      n_bad++; $display("FAIL async_pre_grant: grant_d got %b want 1", grant_d);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({grant_d, mem_valid, d_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL async_reset_now: got gd=%b v=%b dr=%b want 0 0 0", grant_d, mem_valid, d_ready);
    end
    d_valid = 0;
    @(negedge clk);
    reset = 0;
    idle_cycles(1);
  endtask

  task automatic test_random(input int n);
    logic [VW-1:0] e;
    bit i_done = 0, d_done = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1; i_valid = 0; d_valid = 0; i_done = 0; d_done = 0;
      end
      if (!reset) begin
        if (i_valid && i_done) begin
          i_valid = ($urandom_range(0, 3) == 0); i_addr = $urandom & 32'hFFFF_FFFC;
        end else if (i_valid) begin
          if ($urandom_range(0, 49) == 0) i_valid = 0;
        end else if ($urandom_range(0, 1) == 0) begin
          i_valid = 1; i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (d_valid && d_done) begin
          d_valid = 0;
        end else if (d_valid) begin
          if ($urandom_range(0, 49) == 0) d_valid = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          d_valid = 1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = SW'($urandom);
        end
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      e = exp_vec();
      n_cmp++;
      if (dut_vec !== e) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec, e);
      end
      i_done = e[VW-2];
      d_done = e[VW-3];
    end
    @(negedge clk);
    reset = 0; i_valid = 0; d_valid = 0; mem_ready = 0;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_d_write();
    test_burst_refill();
    test_round_robin();
    test_hold_expiry();
    test_abort_stray();
    test_async_reset();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
